// File: rtl/id_ex_stage_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : id_ex_stage_pkg
//  Description : Shared widths, ALU op-class encodings and helpers for the
//                ID/EX pipeline register and its hazard unit.
//  Revision    : 1.0 - initial release
// ============================================================================
package id_ex_stage_pkg;

    localparam int REG_W   = 5;
    localparam int FUNCT_W = 10;
    localparam int ALUOP_W = 2;

    // ALU op classes produced by the decoder
    localparam logic [ALUOP_W-1:0] c_aluop_mem    = 2'b00;
    localparam logic [ALUOP_W-1:0] c_aluop_branch = 2'b01;
    localparam logic [ALUOP_W-1:0] c_aluop_rtype  = 2'b10;
    localparam logic [ALUOP_W-1:0] c_aluop_itype  = 2'b11;

    // True when a non-zero destination feeds either source operand
    function automatic logic rd_feeds_rs(input logic [REG_W-1:0] rd,
                                         input logic [REG_W-1:0] rs1,
                                         input logic [REG_W-1:0] rs2);
        return (rd != '0) && ((rd == rs1) || (rd == rs2));
    endfunction

endpackage : id_ex_stage_pkg
`default_nettype wire

// File: rtl/id_ex_stage_hazard_detect.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_detect
//  Description : Combinational load-use hazard detection. Flags a hazard when
//                a valid load in EX writes a register the ID instruction reads,
//                and derives the front-end stall from it.
//  Revision    : 1.0 - initial release
// ============================================================================
module hazard_detect
    import id_ex_stage_pkg::*;
(
    input  logic             i_ex_valid,
    input  logic             i_ex_memread,
    input  logic [REG_W-1:0] i_ex_rd,
    input  logic             i_id_valid,
    input  logic [REG_W-1:0] i_id_rs1,
    input  logic [REG_W-1:0] i_id_rs2,
    input  logic             i_flush,
    input  logic             i_mem_stall,
    output logic             o_haz,
    output logic             o_stall
);

    // Rs2 is always compared, even for immediate forms, to keep the check simple
    always_comb begin
        o_haz   = i_ex_valid & i_ex_memread & i_id_valid
                & rd_feeds_rs(i_ex_rd, i_id_rs1, i_id_rs2);
        // A flush discards the dependent instruction, and a memory stall
        // already freezes the front end through its own path.
        o_stall = o_haz & ~i_flush & ~i_mem_stall;
    end

endmodule : hazard_detect
`default_nettype wire

// File: rtl/id_ex_stage.sv
`default_nettype none
// ============================================================================
//  Module      : id_ex_stage
//  Description : ID/EX pipeline register with load-use bubble insertion,
//                squash handling, memory-stall freeze and saturating
//                stall/bubble performance counters.
//  Revision    : 1.0 - initial release
// ============================================================================
module id_ex_stage
    import id_ex_stage_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 ID_Valid_i,
    input  logic [REG_W-1:0]     ID_Rs1_i,
    input  logic [REG_W-1:0]     ID_Rs2_i,
    input  logic [REG_W-1:0]     ID_Rd_i,
    input  logic                 ID_RegWrite_i,
    input  logic                 ID_MemRead_i,
    input  logic                 ID_MemWrite_i,
    input  logic                 ID_MemToReg_i,
    input  logic                 ID_ALUSrc_i,
    input  logic [ALUOP_W-1:0]   ID_ALUOp_i,
    input  logic [FUNCT_W-1:0]   ID_Funct_i,
    input  logic [XLEN-1:0]      ID_RS1data_i,
    input  logic [XLEN-1:0]      ID_RS2data_i,
    input  logic [XLEN-1:0]      ID_Imm_i,
    input  logic                 Flush_i,
    input  logic                 MEM_Stall_i,
    output logic                 EX_Valid_o,
    output logic [REG_W-1:0]     EX_Rs1_o,
    output logic [REG_W-1:0]     EX_Rs2_o,
    output logic [REG_W-1:0]     EX_Rd_o,
    output logic                 EX_RegWrite_o,
    output logic                 EX_MemRead_o,
    output logic                 EX_MemWrite_o,
    output logic                 EX_MemToReg_o,
    output logic                 EX_ALUSrc_o,
    output logic [ALUOP_W-1:0]   EX_ALUOp_o,
    output logic [FUNCT_W-1:0]   EX_Funct_o,
    output logic [XLEN-1:0]      EX_RS1data_o,
    output logic [XLEN-1:0]      EX_RS2data_o,
    output logic [XLEN-1:0]      EX_Imm_o,
    output logic                 Stall_o,
    output logic [CNT_W-1:0]     StallCnt_o,
    output logic [CNT_W-1:0]     BubbleCnt_o
);

    typedef struct packed {
        logic               valid;
        logic [REG_W-1:0]   rs1;
        logic [REG_W-1:0]   rs2;
        logic [REG_W-1:0]   rd;
        logic               regwrite;
        logic               memread;
        logic               memwrite;
        logic               memtoreg;
        logic               alusrc;
        logic [ALUOP_W-1:0] aluop;
        logic [FUNCT_W-1:0] funct;
        logic [XLEN-1:0]    rs1data;
        logic [XLEN-1:0]    rs2data;
        logic [XLEN-1:0]    imm;
    } ex_t;

    localparam logic [CNT_W-1:0] c_cnt_one = {{(CNT_W-1){1'b0}}, 1'b1};

    ex_t              r_ex;
    ex_t              w_id;
    ex_t              w_next;
    logic             w_bubble;
    logic             w_haz;
    logic             w_stall;
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_bubble_cnt;

    hazard_detect u_hazard_detect (
        .i_ex_valid   (r_ex.valid),
        .i_ex_memread (r_ex.memread),
        .i_ex_rd      (r_ex.rd),
        .i_id_valid   (ID_Valid_i),
        .i_id_rs1     (ID_Rs1_i),
        .i_id_rs2     (ID_Rs2_i),
        .i_flush      (Flush_i),
        .i_mem_stall  (MEM_Stall_i),
        .o_haz        (w_haz),
        .o_stall      (w_stall)
    );

    // Capture ID fields; an invalid slot keeps its fields but loses every control bit
    always_comb begin
        w_id.valid    = ID_Valid_i;
        w_id.rs1      = ID_Rs1_i;
        w_id.rs2      = ID_Rs2_i;
        w_id.rd       = ID_Rd_i;
        w_id.regwrite = ID_RegWrite_i & ID_Valid_i;
        w_id.memread  = ID_MemRead_i  & ID_Valid_i;
        w_id.memwrite = ID_MemWrite_i & ID_Valid_i;
        w_id.memtoreg = ID_MemToReg_i & ID_Valid_i;
        w_id.alusrc   = ID_ALUSrc_i   & ID_Valid_i;
        w_id.aluop    = ID_Valid_i ? ID_ALUOp_i : c_aluop_mem;
        w_id.funct    = ID_Funct_i;
        w_id.rs1data  = ID_RS1data_i;
        w_id.rs2data  = ID_RS2data_i;
        w_id.imm      = ID_Imm_i;
    end

    // Next EX contents: memory stall holds, flush or hazard inserts an all-zero bubble
    always_comb begin
        w_next   = r_ex;
        w_bubble = 1'b0;
        if (MEM_Stall_i) begin
            w_next = r_ex;
        end else if (Flush_i || w_haz) begin
            // Zeroed Rd/Rs keep the forwarding unit quiet for the bubble
            w_next   = '0;
            w_bubble = 1'b1;
        end else begin
            w_next = w_id;
        end
    end

    // ID/EX pipeline register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_ex <= '0;
        end else begin
            r_ex <= w_next;
        end
    end

    // Saturating performance counters
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_stall_cnt  <= '0;
            r_bubble_cnt <= '0;
        end else begin
            if (w_stall && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + c_cnt_one;
            end
            if (w_bubble && (r_bubble_cnt != '1)) begin
                r_bubble_cnt <= r_bubble_cnt + c_cnt_one;
            end
        end
    end

    assign EX_Valid_o    = r_ex.valid;
    assign EX_Rs1_o      = r_ex.rs1;
    assign EX_Rs2_o      = r_ex.rs2;
    assign EX_Rd_o       = r_ex.rd;
    assign EX_RegWrite_o = r_ex.regwrite;
    assign EX_MemRead_o  = r_ex.memread;
    assign EX_MemWrite_o = r_ex.memwrite;
    assign EX_MemToReg_o = r_ex.memtoreg;
    assign EX_ALUSrc_o   = r_ex.alusrc;
    assign EX_ALUOp_o    = r_ex.aluop;
    assign EX_Funct_o    = r_ex.funct;
    assign EX_RS1data_o  = r_ex.rs1data;
    assign EX_RS2data_o  = r_ex.rs2data;
    assign EX_Imm_o      = r_ex.imm;
    assign Stall_o       = w_stall;
    assign StallCnt_o    = r_stall_cnt;
    assign BubbleCnt_o   = r_bubble_cnt;

endmodule : id_ex_stage
`default_nettype wire
